// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register frame serializer.
// Imported by the serializer and by anything that drives or checks it.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int SHIFT_W = 4;

endpackage

// File: rtl/shift_frame_serializer.sv
// Serializes a parallel word into a shift register's serial input.
// Bit order makes the register hold the word after the last shift.
module shift_frame_serializer
  import shift_pkg::*;
#(
  parameter int   WIDTH    = SHIFT_W,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  input  logic             stall,
  output logic             shift_in,
  output logic             direction,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic [CW-1:0]    idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      word_q  <= '0;
      dir_q   <= DIR_LEFT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          word_d  = load_data;
          dir_d   = load_dir;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (count_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
    endcase
  end

  // Left shifts enter at the LSB, so the MSB must go first.
  always_comb begin
    idx = (dir_q == DIR_RIGHT) ? count_q : LAST - count_q;
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    shift_en   = 1'b0;
    shift_in   = IDLE_BIT;
    unique case (1'b1)
      (state_q == IDLE): begin
        load_ready = 1'b1;
      end
      (state_q == SHIFT): begin
        busy     = 1'b1;
        shift_en = !stall;
        shift_in = word_q[idx];
      end
      default: ;
    endcase
    direction  = dir_q;
    frame_done = done_q;
  end

endmodule

// File: tb/tb_shift_frame_serializer.sv
// Directed and randomized checks of the frame serializer against
// a downstream shift-register model and per-bit order rules.
module tb_shift_frame_serializer;
  import shift_pkg::*;

  localparam int W = SHIFT_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         load_dir;
  logic         stall;
  logic         shift_in;
  logic         direction;
  logic         shift_en;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  shift_frame_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk(clk),
    .reset(rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .load_dir(load_dir),
    .stall(stall),
    .shift_in(shift_in),
    .direction(direction),
    .shift_en(shift_en),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".ready"}, 32'(load_ready), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".shift_en"}, 32'(shift_en), 32'd0);
    chk({tag, ".shift_in"}, 32'(shift_in), 32'd0);
    chk({tag, ".done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic start_load(input logic [W-1:0] w, input logic d,
                            input logic st, input string tag,
                            output int acc);
    tick;
    load_valid = 1'b1;
    load_data  = w;
    load_dir   = d;
    stall      = st;
    #3;
    idle_chk(tag);
    acc = cyc;
  endtask

  // Called in the accept cycle; returns mid-cycle of the done cycle.
  task automatic frame_body(input logic [W-1:0] w, input logic d,
                            input int spct, input bit hold,
                            input logic [W-1:0] nw, input logic nd,
                            input int fat, input int flen,
                            input string tag, output int done_cyc);
    logic [W-1:0] ds;
    logic         eb;
    int           k;
    int           budget;
    int           fst;
    ds = '0;
    k = 0;
    budget = 0;
    fst = 0;
    while (k < W && budget < 4 * W + 8) begin
      tick;
      if (hold) begin
        load_data = nw;
        load_dir  = nd;
      end else begin
        load_valid = 1'b0;
      end
      if (k == fat && fst < flen) begin
        stall = 1'b1;
        fst++;
      end else if (spct > 0) begin
        stall = ($urandom_range(99) < spct);
      end else begin
        stall = 1'b0;
      end
      #3;
      eb = (d == DIR_RIGHT) ? w[k] : w[W-1-k];
      chk({tag, ".bit"}, 32'(shift_in), 32'(eb));
      chk({tag, ".en"}, 32'(shift_en), 32'(!stall));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".ready"}, 32'(load_ready), 32'd0);
      chk({tag, ".dir"}, 32'(direction), 32'(d));
      chk({tag, ".early_done"}, 32'(frame_done), 32'd0);
      if (!stall) begin
        if (d == DIR_RIGHT) ds = {shift_in, ds[W-1:1]};
        else ds = {ds[W-2:0], shift_in};
        k++;
      end
      budget++;
    end
    chk({tag, ".bits_in_budget"}, 32'(k), 32'(W));
    tick;
    if (!hold) load_valid = 1'b0;
    stall = 1'($urandom_range(1));
    #3;
    chk({tag, ".done"}, 32'(frame_done), 32'd1);
    chk({tag, ".done_ready"}, 32'(load_ready), 32'd1);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    chk({tag, ".done_en"}, 32'(shift_en), 32'd0);
    chk({tag, ".done_in"}, 32'(shift_in), 32'd0);
    chk({tag, ".dir_hold"}, 32'(direction), 32'(d));
    chk({tag, ".downstream"}, 32'(ds), 32'(w));
    done_cyc = cyc;
  endtask

  initial begin
    int acc;
    int dc;
    int dc2;
    bit chained;
    logic [W-1:0] cw;
    logic cd;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dir   = 1'b0;
    stall      = 1'b0;

    // Reset then idle
    #2;
    idle_chk("rst");
    chk("rst.dir", 32'(direction), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      stall = 1'(i & 1);
      #3;
      idle_chk("idle");
    end

    // Left frame 1011
    start_load(4'b1011, DIR_LEFT, 1'b0, "left.acc", acc);
    frame_body(4'b1011, DIR_LEFT, 0, 1'b0, '0, 1'b0, -1, 0, "left", dc);
    chk("left.latency", 32'(dc - acc), 32'(W + 1));
    tick;
    #3;
    idle_chk("left.after");

    // Right frame 1000
    start_load(4'b1000, DIR_RIGHT, 1'b0, "right.acc", acc);
    frame_body(4'b1000, DIR_RIGHT, 0, 1'b0, '0, 1'b0, -1, 0, "right", dc);
    tick;
    #3;
    idle_chk("right.after");
    chk("right.dir_idle", 32'(direction), 32'd1);

    // Stall for 3 cycles after the first bit
    start_load(4'b0110, DIR_LEFT, 1'b0, "stall.acc", acc);
    frame_body(4'b0110, DIR_LEFT, 0, 1'b0, '0, 1'b0, 1, 3, "stall", dc);
    chk("stall.latency", 32'(dc - acc), 32'(W + 1 + 3));

    // Back-to-back with load_valid held
    start_load(4'b1111, DIR_LEFT, 1'b0, "b2b.acc", acc);
    frame_body(4'b1111, DIR_LEFT, 0, 1'b1, 4'b0001, DIR_LEFT, -1, 0,
               "b2b1", dc);
    frame_body(4'b0001, DIR_LEFT, 0, 1'b0, '0, 1'b0, -1, 0, "b2b2", dc2);
    chk("b2b.total", 32'(dc2 - acc), 32'd10);

    // Reset mid-frame
    start_load(4'b1100, DIR_RIGHT, 1'b0, "mrst.acc", acc);
    tick;
    load_valid = 1'b0;
    #3;
    chk("mrst.bit0", 32'(shift_in), 32'd0);
    tick;
    #3;
    chk("mrst.bit1", 32'(shift_in), 32'd0);
    tick;
    #1;
    rst_n = 1'b0;
    #1;
    idle_chk("mrst.async");
    chk("mrst.dir", 32'(direction), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick;
      #3;
      idle_chk("mrst.held");
    end
    tick;
    rst_n = 1'b1;
    #3;
    idle_chk("mrst.rel");
    start_load(4'b1100, DIR_RIGHT, 1'b0, "mrst2.acc", acc);
    frame_body(4'b1100, DIR_RIGHT, 0, 1'b0, '0, 1'b0, -1, 0, "mrst2", dc);

    // Randomized frames with random stalls and chaining
    chained = 1'b0;
    cw = '0;
    cd = 1'b0;
    for (int f = 0; f < 24; f++) begin
      logic [W-1:0] w;
      logic d;
      bit h;
      logic [W-1:0] nw;
      logic nd;
      if (chained) begin
        w = cw;
        d = cd;
      end else begin
        w = W'($urandom);
        d = 1'($urandom_range(1));
        start_load(w, d, 1'($urandom_range(1)), "rnd.acc", acc);
      end
      h  = (f < 23) && ($urandom_range(1) == 1);
      nw = W'($urandom);
      nd = 1'($urandom_range(1));
      frame_body(w, d, 30, h, nw, nd, -1, 0, "rnd", dc);
      chained = h;
      cw = nw;
      cd = nd;
    end
    tick;
    load_valid = 1'b0;
    #3;
    idle_chk("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
